// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data RAM between the MEM stage (m0) and the bus slave (m1).
// One access in flight: request seen in cycle N gets its rdy pulse in N+3; losers stay pending until the next IDLE.
module data_ram_arbiter #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int RAM_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_cs,
    input  logic              m0_as,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_rdy,
    output logic              m0_err,

    input  logic              m1_cs,
    input  logic              m1_as,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_rdy,
    output logic              m1_err,

    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state, state_d;
    logic                rr_last, rr_last_d;
    logic                gnt, gnt_d;
    logic                we_q, we_d;
    logic                ok_q, ok_d;

    logic                ram_en_d, ram_we_d;
    logic [RAM_AW-1:0]   ram_addr_d;
    logic [DATA_W-1:0]   ram_wr_data_d;
    logic [DATA_W-1:0]   m0_rd_data_d, m1_rd_data_d;
    logic                m0_rdy_d, m1_rdy_d, m0_err_d, m1_err_d;

    logic                req0, req1, pick;
    logic                sel_we, sel_ok;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wr_data;
    logic [DATA_W-1:0]   resp_data;

    // Request decode and round-robin pick: on a tie the side that did not win last time goes.
    always_comb begin
        req0        = m0_cs & m0_as;
        req1        = m1_cs & m1_as;
        pick        = (req0 && req1) ? ~rr_last : req1;
        sel_we      = pick ? m1_we      : m0_we;
        sel_addr    = pick ? m1_addr    : m0_addr;
        sel_wr_data = pick ? m1_wr_data : m0_wr_data;
        sel_ok      = (sel_addr[ADDR_W-1:RAM_AW] == '0);
        resp_data   = (ok_q && !we_q) ? ram_rd_data : '0;
    end

    // RAM pins are loaded on the grant edge so the strobe is visible during ACCESS.
    always_comb begin
        state_d       = state;
        rr_last_d     = rr_last;
        gnt_d         = gnt;
        we_d          = we_q;
        ok_d          = ok_q;
        ram_en_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr;
        ram_wr_data_d = ram_wr_data;
        m0_rd_data_d  = m0_rd_data;
        m1_rd_data_d  = m1_rd_data;
        m0_rdy_d      = 1'b0;
        m1_rdy_d      = 1'b0;
        m0_err_d      = 1'b0;
        m1_err_d      = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_d       = ACCESS;
                    gnt_d         = pick;
                    rr_last_d     = pick;
                    we_d          = sel_we;
                    ok_d          = sel_ok;
                    ram_en_d      = sel_ok;
                    ram_we_d      = sel_ok & sel_we;
                    ram_addr_d    = sel_addr[RAM_AW-1:0];
                    ram_wr_data_d = sel_wr_data;
                end
            end
            ACCESS: begin
                state_d = WAIT;
            end
            WAIT: begin
                // RAM output is valid this cycle; completion is registered for RESP.
                state_d = RESP;
                if (gnt) begin
                    m1_rd_data_d = resp_data;
                    m1_rdy_d     = 1'b1;
                    m1_err_d     = ~ok_q;
                end else begin
                    m0_rd_data_d = resp_data;
                    m0_rdy_d     = 1'b1;
                    m0_err_d     = ~ok_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_last     <= 1'b1;
            gnt         <= 1'b0;
            we_q        <= 1'b0;
            ok_q        <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
            m0_rd_data  <= '0;
            m1_rd_data  <= '0;
            m0_rdy      <= 1'b0;
            m1_rdy      <= 1'b0;
            m0_err      <= 1'b0;
            m1_err      <= 1'b0;
        end else begin
            state       <= state_d;
            rr_last     <= rr_last_d;
            gnt         <= gnt_d;
            we_q        <= we_d;
            ok_q        <= ok_d;
            ram_en      <= ram_en_d;
            ram_we      <= ram_we_d;
            ram_addr    <= ram_addr_d;
            ram_wr_data <= ram_wr_data_d;
            m0_rd_data  <= m0_rd_data_d;
            m1_rd_data  <= m1_rd_data_d;
            m0_rdy      <= m0_rdy_d;
            m1_rdy      <= m1_rdy_d;
            m0_err      <= m0_err_d;
            m1_err      <= m1_err_d;
        end
    end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Sequences and shares one single-port synchronous data RAM between two requesters: m0 = MEM stage (priority peer), m1 = bus slave port (DMA/peripheral masters).
- Uses the codebase cs/as/rdy handshake per requester.
- Round-robin arbitration; one transaction in flight at a time.
- Drives the RAM enable/write/address/data pins and returns read data with a one-cycle rdy pulse.

Parameters:
- ADDR_W, 30, requester word-address width (`WORD_ADDR).
- DATA_W, 32, word width (`WORD_DATA).
- RAM_AW, 12, RAM index width; depth = 2**RAM_AW = 4096 words.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- m0_cs / m1_cs  in  1  chip select for requester k
- m0_as / m1_as  in  1  address strobe for requester k; a request is cs & as
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  word address
- m0_wr_data / m1_wr_data  in  DATA_W  write data
- m0_rd_data / m1_rd_data  out  DATA_W  read data; registered, valid while the matching rdy = 1
- m0_rdy / m1_rdy  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  one-cycle pulse with rdy when the address is out of range
- ram_en  out  1  RAM access strobe, registered
- ram_we  out  1  RAM write enable, registered
- ram_addr  out  RAM_AW  RAM index, registered
- ram_wr_data  out  DATA_W  RAM write data, registered
- ram_rd_data  in  DATA_W  RAM read data, valid the cycle after ram_en

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - State goes to IDLE; rr_last = 1, so m0 wins the first tie.
  - All outputs go to 0: rd_data, rdy, err, ram_*.
  - Any in-flight transaction is aborted with no rdy; a write already strobed may have landed.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Evaluates req0 = m0_cs & m0_as and req1 = m1_cs & m1_as.
  - One request: grant it. Both: grant the requester other than rr_last. None: stay in IDLE.
  - On grant, latch grant id, we, addr and wr_data into internal registers.
  - range_ok = (addr[ADDR_W-1:RAM_AW] == 0).
  - Transition to ACCESS; rr_last <= grant id.
- ACCESS (cycle N+1 for a request seen in cycle N):
  - If range_ok: ram_en = 1, ram_we = latched we, ram_addr = addr[RAM_AW-1:0], ram_wr_data = latched data.
  - If not range_ok: ram_en = 0.
  - Go to WAIT.
- WAIT (N+2):
  - ram_en = 0, ram_we = 0.
  - For a granted read with range_ok: capture ram_rd_data into the granted rd_data register at the end of this cycle.
  - For a write or an out-of-range access: load rd_data with 0.
  - Go to RESP.
- RESP (N+3):
  - Granted rdy = 1 for exactly one cycle; granted err = !range_ok.
  - The other requester's rdy/err stay 0.
  - Go to IDLE.
- Latency: request sampled in cycle N -> rdy in cycle N+3 (reads and writes alike). Minimum 4 cycles per transaction; peak throughput 1 access / 4 cycles.
- rd_data holds its value after rdy until that requester's next completion.
- Requester obligations:
  - Hold cs/as/we/addr/wr_data stable from assertion through the rdy cycle.
  - Drop as no later than the cycle after rdy. IDLE re-samples in N+4, so a registered requester is safe.
- Mid-transaction withdrawal: inputs are latched at grant, so deasserting as after grant does not cancel; the access completes and rdy still pulses.
- Starvation: under continuous requests from both sides, grants strictly alternate m0, m1, m0, ...
- A losing request stays pending (no rdy) and is granted in the next IDLE.
- No other error conditions exist; a write to range_ok addresses always commits in ACCESS.

Test Plan:
- Single read: preload RAM[0x010] = 0xDEADBEEF; m0 reads addr 0x010 in cycle 0 -> ram_en = 1, ram_we = 0, ram_addr = 0x010 in cycle 1; m0_rdy = 1 and m0_rd_data = 0xDEADBEEF in cycle 3; m0_err = 0; m1_rdy stays 0.
- Write then read: m1 writes 0x12345678 to 0xFFF (ram_we = 1 in cycle 1, m1_rdy in cycle 3); m1 then reads 0xFFF -> m1_rd_data = 0x12345678; boundary index 4095 works.
- Contention: both request from reset in the same cycle and hold through 4 transactions -> grant order m0, m1, m0, m1; rdy pulses at cycles 3, 7, 11, 15; no lost or duplicated rdy.
- Out of range: m0 reads addr 0x1000 -> ram_en never asserts; m0_rdy = m0_err = 1 in cycle 3 with m0_rd_data = 0; a following in-range read returns correct data.
- Reset mid-operation: rst_n = 0 at cycle 2 of an m1 read -> next cycle all outputs 0, state IDLE, no m1_rdy; after release, simultaneous requests grant m0 first.
- Withdrawal: m0 drops as in cycle 1 after a read grant -> m0_rdy still pulses in cycle 3 with correct data; IDLE at cycle 4 does not re-grant m0.
